response_encoder: RTL and testbench
===================================

RESPONSE_ENCODER -- requirements
Module: response_encoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter SCREEN_W, default 320: pixel X bound (exclusive).
REQ-003 Parameter SCREEN_H, default 200: pixel Y bound (exclusive).
REQ-004 Ports SHALL be:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- pix_req_valid  in  1  pixel readback request
- pix_req_x  in  16  requested X
- pix_req_y  in  16  requested Y
- pal_req_valid  in  1  palette readback request
- pal_req_index  in  8  requested palette index
- encoder_ready  out  1  request accept strobe
- fb_read_x  out  9  framebuffer read X
- fb_read_y  out  8  framebuffer read Y
- fb_read_data  in  8  framebuffer read data, 1-cycle latency
- palette_read_index  out  8  palette read address
- palette_read_r, palette_read_g, palette_read_b  in  4 each  palette data, 1-cycle latency
- tx_data  out  8  byte to UART transmitter
- tx_data_valid  out  1  tx_data holds a byte
- tx_ready  in  1  UART transmitter can take a byte

Function
REQ-005 States SHALL be: IDLE, ADDR, CAPT, SEND; encoder_ready SHALL be high exactly in IDLE.
REQ-006 A request SHALL be accepted on an IDLE cycle with its valid high; pixel SHALL win when both are valid, and palette SHALL stay pending (requester holds valid).
REQ-007 Requests SHALL NOT be accepted outside IDLE.
REQ-008 Pixel accept with pix_req_x<SCREEN_W and pix_req_y<SCREEN_H:
- fb_read_x/fb_read_y SHALL be registered from the low bits of X/Y.
- IDLE->ADDR->CAPT; fb_read_data SHALL be captured in CAPT.
- CAPT->SEND.
REQ-009 Pixel accept out of range: no framebuffer read; go straight IDLE->SEND with error frame 0xEE,0x01.
REQ-010 Palette accept:
- palette_read_index SHALL be registered from pal_req_index.
- IDLE->ADDR->CAPT; R/G/B captured in CAPT.
- CAPT->SEND.
REQ-011 Pixel frame SHALL be 0x81, X[15:8], X[7:0], Y[15:8], Y[7:0], COLOR (6 bytes), with X/Y the original 16-bit request values.
REQ-012 Palette frame SHALL be 0x82, INDEX, {R,R}, {G,G}, {B,B} (5 bytes); each 4-bit component is nibble-replicated to 8 bits.
REQ-013 In SEND, tx_data_valid SHALL be high and tx_data stable until a cycle with tx_ready high; the byte index SHALL advance on that edge.
REQ-014 After the last byte is transferred, state SHALL return to IDLE; tx_data_valid SHALL be low the following cycle.
REQ-015 For an in-range request, the first byte SHALL appear with tx_data_valid high on the 3rd cycle after the accept edge; for an error frame, on the 1st.
REQ-016 tx_ready high while not in SEND SHALL have no effect.

Reset
REQ-017 Reset SHALL force IDLE, byte index 0, tx_data_valid=0, tx_data=0, fb_read_x=0, fb_read_y=0, palette_read_index=0, encoder_ready=1.
REQ-018 Reset mid-frame SHALL abort the frame; no remaining bytes are sent after reset deasserts.

Configuration
REQ-019 With RESP_CHECKSUM_EN defined, every frame (including error frames) SHALL append one byte: the XOR of all preceding frame bytes. Frame lengths become 7/6/3.
REQ-020 Without RESP_CHECKSUM_EN, no checksum byte or checksum logic SHALL exist.

Verification
REQ-021 Pixel request x=0x0005, y=0x0007, fb_read_data=0x3C, tx_ready=1 -> bytes 81 00 05 00 07 3C; encoder_ready high again after the last byte.
REQ-022 Palette request index=0x10, R=0xA, G=0x5, B=0xF -> bytes 82 10 AA 55 FF (RESP_CHECKSUM_EN: additional byte 0x82^0x10^0xAA^0x55^0xFF=0x92).
REQ-023 Pixel request x=320, y=0 -> bytes EE 01; no change on fb_read_x/fb_read_y.
REQ-024 pix_req_valid and pal_req_valid high together in IDLE -> pixel frame sent first, palette frame sent immediately after.
REQ-025 tx_ready low for 10 cycles during byte 3 -> tx_data and tx_data_valid held unchanged; no byte skipped or duplicated.
REQ-026 Reset asserted during byte 2 of a pixel frame -> tx_data_valid low the next cycle, encoder_ready=1, no further frame bytes.

Source files
------------

// File: rtl/response_encoder.sv
// Response encoder: serialises pixel and palette readback results into byte
// frames for a UART transmitter.
// Optional feature: define RESP_CHECKSUM_EN to append an XOR checksum byte to
// every frame.
module response_encoder #(
   parameter int unsigned SCREEN_W = 320,
   parameter int unsigned SCREEN_H = 200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_req_valid,
   input  logic [15:0] pix_req_x,
   input  logic [15:0] pix_req_y,
   input  logic        pal_req_valid,
   input  logic [7:0]  pal_req_index,
   output logic        encoder_ready,
   output logic [8:0]  fb_read_x,
   output logic [7:0]  fb_read_y,
   input  logic [7:0]  fb_read_data,
   output logic [7:0]  palette_read_index,
   input  logic [3:0]  palette_read_r,
   input  logic [3:0]  palette_read_g,
   input  logic [3:0]  palette_read_b,
   output logic [7:0]  tx_data,
   output logic        tx_data_valid,
   input  logic        tx_ready
);

   typedef enum logic [1:0] {StIdle, StAddr, StCapt, StSend} state_e;
   typedef enum logic [1:0] {KindPix, KindPal, KindErr} kind_e;

   localparam logic [15:0] ScreenW = 16'(SCREEN_W);
   localparam logic [15:0] ScreenH = 16'(SCREEN_H);

   // Index of the final byte of each frame type
`ifdef RESP_CHECKSUM_EN
   localparam logic [2:0] PixLast = 3'd6;
   localparam logic [2:0] PalLast = 3'd5;
   localparam logic [2:0] ErrLast = 3'd2;
`else
   localparam logic [2:0] PixLast = 3'd5;
   localparam logic [2:0] PalLast = 3'd4;
   localparam logic [2:0] ErrLast = 3'd1;
`endif

   state_e      state_q, state_d;
   kind_e       kind_q;
   logic [2:0]  idx_q;
   logic [15:0] x_q, y_q;
   logic [7:0]  color_q;
   logic [3:0]  r_q, g_q, b_q;
`ifdef RESP_CHECKSUM_EN
   logic [7:0]  csum_q;
`endif

   logic        in_range;
   logic [2:0]  last_idx;
   logic        byte_done;
   logic [7:0]  byte_sel;

   assign in_range  = (pix_req_x < ScreenW) && (pix_req_y < ScreenH);
   assign byte_done = (state_q == StSend) && tx_ready;

   // Frame byte selection and frame length per frame type
   always_comb begin
      byte_sel = 8'h00;
      last_idx = ErrLast;
      unique case (kind_q)
         KindPix: begin
            last_idx = PixLast;
            case (idx_q)
               3'd0:    byte_sel = 8'h81;
               3'd1:    byte_sel = x_q[15:8];
               3'd2:    byte_sel = x_q[7:0];
               3'd3:    byte_sel = y_q[15:8];
               3'd4:    byte_sel = y_q[7:0];
               3'd5:    byte_sel = color_q;
`ifdef RESP_CHECKSUM_EN
               default: byte_sel = csum_q;
`else
               default: byte_sel = 8'h00;
`endif
            endcase
         end
         KindPal: begin
            last_idx = PalLast;
            case (idx_q)
               3'd0:    byte_sel = 8'h82;
               3'd1:    byte_sel = palette_read_index;
               3'd2:    byte_sel = {r_q, r_q};
               3'd3:    byte_sel = {g_q, g_q};
               3'd4:    byte_sel = {b_q, b_q};
`ifdef RESP_CHECKSUM_EN
               default: byte_sel = csum_q;
`else
               default: byte_sel = 8'h00;
`endif
            endcase
         end
         default: begin
            last_idx = ErrLast;
            case (idx_q)
               3'd0:    byte_sel = 8'hEE;
               3'd1:    byte_sel = 8'h01;
`ifdef RESP_CHECKSUM_EN
               default: byte_sel = csum_q;
`else
               default: byte_sel = 8'h00;
`endif
            endcase
         end
      endcase
   end

   // Next-state logic and handshake outputs
   always_comb begin
      state_d       = state_q;
      encoder_ready = 1'b0;
      tx_data_valid = 1'b0;
      tx_data       = 8'h00;
      unique case (state_q)
         StIdle: begin
            encoder_ready = 1'b1;
            if (pix_req_valid) begin
               state_d = in_range ? StAddr : StSend;
            end else if (pal_req_valid) begin
               state_d = StAddr;
            end
         end
         StAddr: state_d = StCapt;
         StCapt: state_d = StSend;
         StSend: begin
            tx_data_valid = 1'b1;
            tx_data       = byte_sel;
            if (tx_ready && (idx_q == last_idx)) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, request capture, read-data capture and byte index
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q            <= StIdle;
         kind_q             <= KindPix;
         idx_q              <= 3'd0;
         x_q                <= 16'h0000;
         y_q                <= 16'h0000;
         color_q            <= 8'h00;
         r_q                <= 4'h0;
         g_q                <= 4'h0;
         b_q                <= 4'h0;
         fb_read_x          <= 9'h000;
         fb_read_y          <= 8'h00;
         palette_read_index <= 8'h00;
`ifdef RESP_CHECKSUM_EN
         csum_q             <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         if (state_q == StIdle) begin
            if (pix_req_valid) begin
               x_q <= pix_req_x;
               y_q <= pix_req_y;
               if (in_range) begin
                  kind_q    <= KindPix;
                  fb_read_x <= pix_req_x[8:0];
                  fb_read_y <= pix_req_y[7:0];
               end else begin
                  kind_q <= KindErr;
               end
            end else if (pal_req_valid) begin
               kind_q             <= KindPal;
               palette_read_index <= pal_req_index;
            end
         end
         if (state_q == StCapt) begin
            if (kind_q == KindPix) begin
               color_q <= fb_read_data;
            end else begin
               r_q <= palette_read_r;
               g_q <= palette_read_g;
               b_q <= palette_read_b;
            end
         end
         if (byte_done) begin
            idx_q <= (idx_q == last_idx) ? 3'd0 : idx_q + 3'd1;
`ifdef RESP_CHECKSUM_EN
            csum_q <= (idx_q == last_idx) ? 8'h00 : csum_q ^ byte_sel;
`endif
         end
      end
   end

endmodule

// File: tb/tb_response_encoder.sv
// Directed bench for response_encoder. Honours RESP_CHECKSUM_EN when defined.
module tb_response_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        pix_req_valid;
   logic [15:0] pix_req_x, pix_req_y;
   logic        pal_req_valid;
   logic [7:0]  pal_req_index;
   logic        encoder_ready;
   logic [8:0]  fb_read_x;
   logic [7:0]  fb_read_y;
   logic [7:0]  fb_read_data;
   logic [7:0]  palette_read_index;
   logic [3:0]  palette_read_r, palette_read_g, palette_read_b;
   logic [7:0]  tx_data;
   logic        tx_data_valid;
   logic        tx_ready;

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] exp_q[$];
   logic drop_pix = 1'b0;
   logic drop_pal = 1'b0;

   always #5 clk = ~clk;

   response_encoder #(.SCREEN_W(320), .SCREEN_H(200)) dut (
      .clk                (clk),
      .reset              (reset),
      .pix_req_valid      (pix_req_valid),
      .pix_req_x          (pix_req_x),
      .pix_req_y          (pix_req_y),
      .pal_req_valid      (pal_req_valid),
      .pal_req_index      (pal_req_index),
      .encoder_ready      (encoder_ready),
      .fb_read_x          (fb_read_x),
      .fb_read_y          (fb_read_y),
      .fb_read_data       (fb_read_data),
      .palette_read_index (palette_read_index),
      .palette_read_r     (palette_read_r),
      .palette_read_g     (palette_read_g),
      .palette_read_b     (palette_read_b),
      .tx_data            (tx_data),
      .tx_data_valid      (tx_data_valid),
      .tx_ready           (tx_ready)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Appends the XOR of the bytes pushed since frame start when checksums are on
   task automatic push_csum(input int start);
`ifdef RESP_CHECKSUM_EN
      logic [7:0] c = 8'h00;
      for (int i = start; i < exp_q.size(); i++) c ^= exp_q[i];
      exp_q.push_back(c);
`endif
   endtask

   task automatic exp_pix(input logic [15:0] x, input logic [15:0] y, input logic [7:0] c);
      int s = exp_q.size();
      exp_q.push_back(8'h81); exp_q.push_back(x[15:8]); exp_q.push_back(x[7:0]);
      exp_q.push_back(y[15:8]); exp_q.push_back(y[7:0]); exp_q.push_back(c);
      push_csum(s);
   endtask

   task automatic exp_pal(input logic [7:0] i, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b);
      int s = exp_q.size();
      exp_q.push_back(8'h82); exp_q.push_back(i);
      exp_q.push_back(r); exp_q.push_back(g); exp_q.push_back(b);
      push_csum(s);
   endtask

   task automatic exp_err();
      int s = exp_q.size();
      exp_q.push_back(8'hEE); exp_q.push_back(8'h01);
      push_csum(s);
   endtask

   // Called at a negedge right after request valids are raised. Drops each valid
   // once accepted, stalls tx_ready for 10 cycles at byte stall_idx, or asserts
   // reset when byte rst_at is on the bus. first_cyc counts cycles after accept.
   task automatic collect(input string tag, input int stall_idx, input int rst_at,
                          output int first_cyc);
      int k = 0;
      int cyc = 0;
      int stalled = 0;
      first_cyc = -1;
      while (k < exp_q.size() && cyc < 300) begin
         if (drop_pix) begin pix_req_valid = 1'b0; drop_pix = 1'b0; end
         if (drop_pal) begin pal_req_valid = 1'b0; drop_pal = 1'b0; end
         if (encoder_ready) begin
            if (pix_req_valid) drop_pix = 1'b1;
            else if (pal_req_valid) drop_pal = 1'b1;
         end
         if (tx_data_valid && first_cyc < 0) first_cyc = cyc;
         if (rst_at == k && tx_data_valid) begin
            reset = 1'b1;
            break;
         end
         if (k == stall_idx && stalled < 10 && (tx_data_valid || stalled > 0)) begin
            check({tag, "_stall_valid"}, 16'(tx_data_valid), 16'd1);
            check({tag, "_stall_data"}, 16'(tx_data), 16'(exp_q[k]));
            tx_ready = 1'b0;
            stalled++;
         end else begin
            tx_ready = 1'b1;
            if (tx_data_valid) begin
               check($sformatf("%s_byte%0d", tag, k), 16'(tx_data), 16'(exp_q[k]));
               k++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      if (drop_pix) begin pix_req_valid = 1'b0; drop_pix = 1'b0; end
      if (drop_pal) begin pal_req_valid = 1'b0; drop_pal = 1'b0; end
      tx_ready = 1'b1;
      if (rst_at < 0) check({tag, "_count"}, 16'(k), 16'(exp_q.size()));
   endtask

   initial begin
      int fc;
      int extra;
      reset = 1'b1;
      pix_req_valid = 1'b0; pix_req_x = '0; pix_req_y = '0;
      pal_req_valid = 1'b0; pal_req_index = '0;
      fb_read_data = 8'h3C;
      palette_read_r = 4'hA; palette_read_g = 4'h5; palette_read_b = 4'hF;
      tx_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready", 16'(encoder_ready), 16'd1);
      check("rst_valid", 16'(tx_data_valid), 16'd0);
      check("rst_data", 16'(tx_data), 16'h0);
      check("rst_fbx", 16'(fb_read_x), 16'h0);
      check("rst_fby", 16'(fb_read_y), 16'h0);
      check("rst_pidx", 16'(palette_read_index), 16'h0);
      reset = 1'b0;
      @(negedge clk);

      // Pixel 5,7
      exp_q.delete(); exp_pix(16'h0005, 16'h0007, 8'h3C);
      pix_req_x = 16'h0005; pix_req_y = 16'h0007; pix_req_valid = 1'b1;
      collect("pix", -1, -1, fc);
      check("pix_lat", 16'(fc), 16'd3);
      check("pix_end_valid", 16'(tx_data_valid), 16'd0);
      check("pix_end_ready", 16'(encoder_ready), 16'd1);
      check("pix_fbx", 16'(fb_read_x), 16'h005);
      check("pix_fby", 16'(fb_read_y), 16'h07);

      // Palette index 0x10
      exp_q.delete(); exp_pal(8'h10, 8'hAA, 8'h55, 8'hFF);
      pal_req_index = 8'h10; pal_req_valid = 1'b1;
      collect("pal", -1, -1, fc);
      check("pal_lat", 16'(fc), 16'd3);
      check("pal_idx", 16'(palette_read_index), 16'h10);
      check("pal_end_ready", 16'(encoder_ready), 16'd1);

      // Out of range X=320: error frame, framebuffer address untouched
      exp_q.delete(); exp_err();
      pix_req_x = 16'd320; pix_req_y = 16'd0; pix_req_valid = 1'b1;
      collect("errx", -1, -1, fc);
      check("errx_lat", 16'(fc), 16'd1);
      check("errx_fbx", 16'(fb_read_x), 16'h005);
      check("errx_fby", 16'(fb_read_y), 16'h07);

      // Out of range Y=200
      exp_q.delete(); exp_err();
      pix_req_x = 16'd0; pix_req_y = 16'd200; pix_req_valid = 1'b1;
      collect("erry", -1, -1, fc);
      check("erry_lat", 16'(fc), 16'd1);

      // Simultaneous requests, pixel at the in-range corner 319,199
      exp_q.delete();
      exp_pix(16'd319, 16'd199, 8'h3C);
      exp_pal(8'h10, 8'hAA, 8'h55, 8'hFF);
      pix_req_x = 16'd319; pix_req_y = 16'd199; pix_req_valid = 1'b1;
      pal_req_valid = 1'b1;
      collect("dual", -1, -1, fc);
      check("dual_lat", 16'(fc), 16'd3);
      check("dual_fbx", 16'(fb_read_x), 16'h13F);
      check("dual_fby", 16'(fb_read_y), 16'hC7);
      check("dual_end_ready", 16'(encoder_ready), 16'd1);

      // Back-pressure on the third byte
      exp_q.delete(); exp_pix(16'h00A0, 16'h0064, 8'h3C);
      pix_req_x = 16'h00A0; pix_req_y = 16'h0064; pix_req_valid = 1'b1;
      collect("stall", 2, -1, fc);
      check("stall_end_valid", 16'(tx_data_valid), 16'd0);

      // Reset while the second byte of a pixel frame is on the bus
      exp_q.delete(); exp_pix(16'h0005, 16'h0007, 8'h3C);
      pix_req_x = 16'h0005; pix_req_y = 16'h0007; pix_req_valid = 1'b1;
      collect("rstmid", -1, 1, fc);
      check("rstmid_hit", 16'(reset), 16'd1);
      @(negedge clk);
      check("rstmid_valid", 16'(tx_data_valid), 16'd0);
      check("rstmid_ready", 16'(encoder_ready), 16'd1);
      check("rstmid_data", 16'(tx_data), 16'h0);
      reset = 1'b0;
      extra = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx_data_valid) extra++;
      end
      check("rstmid_no_bytes", 16'(extra), 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
